// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit.
// Size encodings, FSM states and lane constants.
package mem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Number of bytes moved by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        logic [2:0] n;
        case (s)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Lane alignment for the memory access unit: byte enables,
// split detection, store positioning and load extraction.
module mau_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] wdata,
    input  logic [63:0] rbuf,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [63:0] w,
    output logic [31:0] result
);

    logic [2:0]  n;
    logic [7:0]  mask;
    logic [7:0]  lanes;
    logic [31:0] wmask;
    logic [63:0] sh;
    logic [5:0]  bits;

    // Lane enables across a two-word window; upper nibble is beat 1.
    always_comb begin
        n     = size_bytes(size);
        mask  = 8'((9'd1 << n) - 9'd1);
        lanes = mask << off;
        be0   = lanes[3:0];
        be1   = lanes[7:4];
        split = ({1'b0, off} + n) > 3'd4;
    end

    // Store data positioned into the two-word window.
    always_comb begin
        bits = {1'b0, off, 3'b000};
        case (size)
            SZ_B:    wmask = 32'h0000_00FF;
            SZ_H:    wmask = 32'h0000_FFFF;
            default: wmask = 32'hFFFF_FFFF;
        endcase
        w = {32'h0, wdata & wmask} << bits;
    end

    // Load data shifted down to lane 0 and extended.
    always_comb begin
        sh = rbuf >> bits;
        case (size)
            SZ_B:    result = zext ? {24'h0, sh[7:0]}
                                   : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    result = zext ? {16'h0, sh[15:0]}
                                   : {{16{sh[15]}}, sh[15:0]};
            default: result = sh[31:0];
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: byte/half/word loads and stores
// against a word-organised handshaked RAM, with boundary splits.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          zext,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          m_valid,
    output logic          m_we,
    output logic [AW-3:0] m_addr,
    output logic [3:0]    m_be,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata
);

    state_t        state;
    state_t        nstate;
    logic          we_q;
    logic [1:0]    size_q;
    logic          zext_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [63:0]   rbuf;
    logic          start;
    logic          split;
    logic [3:0]    be0;
    logic [3:0]    be1;
    logic [63:0]   w;
    logic [31:0]   result;
    logic [AW-3:0] waddr0;
    logic [AW-3:0] waddr1;

    assign start  = (state == IDLE) && req && (size != SZ_X);
    assign waddr0 = addr_q[AW-1:2];
    assign waddr1 = waddr0 + 1'b1;

    mau_lane_align u_align (
        .off    (addr_q[1:0]),
        .size   (size_q),
        .zext   (zext_q),
        .wdata  (wdata_q),
        .rbuf   (rbuf),
        .be0    (be0),
        .be1    (be1),
        .split  (split),
        .w      (w),
        .result (result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= nstate;
    end

    // Next-state logic: one or two beats, then a completion cycle.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (start)   nstate = BEAT0;
            BEAT0: if (m_ready) nstate = split ? BEAT1 : FIN;
            BEAT1: if (m_ready) nstate = FIN;
            FIN:                nstate = IDLE;
        endcase
    end

    // RAM request outputs, held constant for the whole beat.
    always_comb begin
        m_valid = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_be    = '0;
        m_wdata = '0;
        busy    = (state != IDLE);
        unique case (state)
            BEAT0: begin
                m_valid = 1'b1;
                m_we    = we_q;
                m_addr  = waddr0;
                m_be    = be0;
                m_wdata = w[31:0];
            end
            BEAT1: begin
                m_valid = 1'b1;
                m_we    = we_q;
                m_addr  = waddr1;
                m_be    = be1;
                m_wdata = w[63:32];
            end
            default: ;
        endcase
    end

    // Request capture, read buffer and registered completion outputs.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            zext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
            rdata   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= (state == FIN);
            err  <= (state == IDLE) && req && (size == SZ_X);
            if (start) begin
                we_q    <= we;
                size_q  <= size;
                zext_q  <= zext;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == BEAT0 && m_ready) rbuf[31:0]  <= m_rdata;
            if (state == BEAT1 && m_ready) rbuf[63:32] <= m_rdata;
            if (state == FIN && !we_q)     rdata       <= result;
        end
    end

endmodule
